// File: rtl/shift_sequencer.sv
// Iterative shifter: drives a one-position shift datapath for SLL/SRL/SRA/ROL, one step per clock.
// Optional macro SHIFT_SEQ_FAST_EN: two positions per clock while at least two remain.
module shift_sequencer #(
    parameter int N       = 8,
    parameter int SHAMT_W = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [1:0]         op,
    input  logic [N-1:0]       data_in,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               busy,
    output logic               done,
    output logic [N-1:0]       result
);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    localparam logic [SHAMT_W-1:0] ONE = SHAMT_W'(1);

    state_t             r_state;
    logic [SHAMT_W-1:0] r_count;
    logic [1:0]         r_op;
    logic [N-1:0]       r_work;
    logic               r_busy;
    logic               r_done;

    logic [N-1:0]       w_next_work;
    logic [SHAMT_W-1:0] w_next_count;
    logic               w_last;

    function automatic logic [N-1:0] shift_one(input logic [1:0] f_op, input logic [N-1:0] f_w);
        logic [N-1:0] f_res;
        case (f_op)
            2'b00:   f_res = {f_w[N-2:0], 1'b0};
            2'b01:   f_res = {1'b0, f_w[N-1:1]};
            2'b10:   f_res = {f_w[N-1], f_w[N-1:1]};
            default: f_res = {f_w[N-2:0], f_w[N-1]};
        endcase
        return f_res;
    endfunction

`ifdef SHIFT_SEQ_FAST_EN
    // Count is zero-extended so the compare against 2 stays valid for any SHAMT_W.
    localparam logic [SHAMT_W:0] TWO = (SHAMT_W+1)'(2);

    always_comb begin
        w_next_work  = shift_one(r_op, r_work);
        w_next_count = r_count - ONE;
        w_last       = ({1'b0, r_count} <= TWO);
        if ({1'b0, r_count} >= TWO) begin
            w_next_work  = shift_one(r_op, shift_one(r_op, r_work));
            w_next_count = r_count - SHAMT_W'(2);
        end
    end
`else
    always_comb begin
        w_next_work  = shift_one(r_op, r_work);
        w_next_count = r_count - ONE;
        w_last       = (r_count == ONE);
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_count <= '0;
            r_op    <= 2'b00;
            r_work  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                SHIFT: begin
                    r_work  <= w_next_work;
                    r_count <= w_next_count;
                    if (w_last) begin
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: begin
                    // IDLE and DONE both accept a new request, which allows back-to-back operations.
                    if (start) begin
                        r_work  <= data_in;
                        r_count <= shamt;
                        r_op    <= op;
                        if (shamt == '0) begin
                            r_state <= DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= SHIFT;
                            r_busy  <= 1'b1;
                            r_done  <= 1'b0;
                        end
                    end else begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign result = r_work;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed, table-driven bench for shift_sequencer, plus hand sequences for busy, back-to-back and reset.
// Expected latencies follow SHIFT_SEQ_FAST_EN when the bench is built with it.
module tb_shift_sequencer;

    localparam int N  = 8;
    localparam int SW = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [1:0]    op;
    logic [N-1:0]  dataIn;
    logic [SW-1:0] shamt;
    logic          busy;
    logic          done;
    logic [N-1:0]  result;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string         name;
        logic [1:0]    op;
        logic [N-1:0]  data;
        logic [SW-1:0] shamt;
        logic [N-1:0]  expResult;
    } vector_t;

    vector_t vectors[9];

    always #5 clk = ~clk;

    shift_sequencer #(.N(N), .SHAMT_W(SW)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .op      (op),
        .data_in (dataIn),
        .shamt   (shamt),
        .busy    (busy),
        .done    (done),
        .result  (result)
    );

    // Edges after the accepting edge until done is visible.
    function automatic int latencyOf(input int k);
`ifdef SHIFT_SEQ_FAST_EN
        return (k + 1) / 2;
`else
        return k;
`endif
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Called at a negedge; counts edges until done is seen, bounded so a stuck DUT cannot hang the run.
    task automatic waitForDone(input int startLat, output int lat, output bit sawBusy, output bit overlap);
        lat     = startLat;
        sawBusy = 1'b0;
        overlap = 1'b0;
        while (done !== 1'b1 && lat < 40) begin
            if (busy === 1'b1) sawBusy = 1'b1;
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        if (busy === 1'b1 && done === 1'b1) overlap = 1'b1;
    endtask

    task automatic applyStimulus(input vector_t v);
        int lat;
        bit sawBusy;
        bit overlap;
        @(negedge clk);
        op     = v.op;
        dataIn = v.data;
        shamt  = v.shamt;
        start  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        // Inputs are free to change once the request has been taken.
        start  = 1'b0;
        op     = ~v.op;
        dataIn = ~v.data;
        shamt  = ~v.shamt;
        waitForDone(0, lat, sawBusy, overlap);
        checkOutput({v.name, " latency"}, 32'(lat), 32'(latencyOf(int'(v.shamt))));
        checkOutput({v.name, " result"}, 32'(result), 32'(v.expResult));
        checkOutput({v.name, " busy seen"}, 32'(sawBusy), 32'(v.shamt != '0));
        checkOutput({v.name, " busy with done"}, 32'(overlap), 32'(0));
        @(posedge clk);
        @(negedge clk);
        checkOutput({v.name, " done width"}, 32'(done), 32'(0));
        checkOutput({v.name, " idle busy"}, 32'(busy), 32'(0));
        checkOutput({v.name, " result hold"}, 32'(result), 32'(v.expResult));
    endtask

    initial begin
        int lat;
        bit sawBusy;
        bit overlap;
        int donePulses;

        vectors[0] = '{"sll3",   2'b00, 8'h96, 3'd3, 8'hB0};
        vectors[1] = '{"srl2",   2'b01, 8'h96, 3'd2, 8'h25};
        vectors[2] = '{"sra2",   2'b10, 8'h96, 3'd2, 8'hE5};
        vectors[3] = '{"rol3",   2'b11, 8'h96, 3'd3, 8'hB4};
        vectors[4] = '{"zero",   2'b00, 8'h5A, 3'd0, 8'h5A};
        vectors[5] = '{"sll7",   2'b00, 8'h01, 3'd7, 8'h80};
        vectors[6] = '{"sra2neg",2'b10, 8'h80, 3'd2, 8'hE0};
        vectors[7] = '{"rol1",   2'b11, 8'h81, 3'd1, 8'h03};
        vectors[8] = '{"srl7",   2'b01, 8'h81, 3'd7, 8'h01};

        // Reset held while start toggles must keep everything cleared.
        rst_n  = 1'b0;
        start  = 1'b0;
        op     = 2'b00;
        dataIn = 8'hA5;
        shamt  = 3'd3;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            start = ~start;
        end
        checkOutput("reset busy", 32'(busy), 32'(0));
        checkOutput("reset done", 32'(done), 32'(0));
        checkOutput("reset result", 32'(result), 32'(0));
        @(negedge clk);
        start = 1'b0;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("idle busy", 32'(busy), 32'(0));
        checkOutput("idle done", 32'(done), 32'(0));
        checkOutput("idle result", 32'(result), 32'(0));

        for (int i = 0; i < 9; i++) begin
            applyStimulus(vectors[i]);
        end

        // Start while busy is ignored.
        @(negedge clk);
        op = 2'b00; dataIn = 8'h01; shamt = 3'd7; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        op = 2'b01; dataIn = 8'hFF; shamt = 3'd1; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        waitForDone(2, lat, sawBusy, overlap);
        checkOutput("ignore latency", 32'(lat), 32'(latencyOf(7)));
        checkOutput("ignore result", 32'(result), 32'h80);
        checkOutput("ignore busy with done", 32'(overlap), 32'(0));

        // Back-to-back: new request during the done cycle.
        op = 2'b01; dataIn = 8'h80; shamt = 3'd1; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        checkOutput("b2b busy", 32'(busy), 32'(1));
        checkOutput("b2b done low", 32'(done), 32'(0));
        waitForDone(0, lat, sawBusy, overlap);
        checkOutput("b2b latency", 32'(lat), 32'(latencyOf(1)));
        checkOutput("b2b result", 32'(result), 32'h40);
        @(posedge clk);
        @(negedge clk);

        // Reset in the middle of a shift aborts with no done pulse.
        op = 2'b00; dataIn = 8'h0F; shamt = 3'd5; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        checkOutput("abort busy before", 32'(busy), 32'(1));
        rst_n = 1'b0;
        #1;
        checkOutput("abort busy", 32'(busy), 32'(0));
        checkOutput("abort done", 32'(done), 32'(0));
        checkOutput("abort result", 32'(result), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;
        donePulses = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) donePulses++;
        end
        checkOutput("abort no done", 32'(donePulses), 32'(0));
        checkOutput("abort result after", 32'(result), 32'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/shift_sequencer.md
Name: shift_sequencer

Overview:
- Multi-cycle controller that drives a single-position shift datapath iteratively to perform a variable-amount shift.
- Supports logical left, logical right, arithmetic right and rotate left.
- Sits between the ALU control path and the n-bit shift datapath, with a start/busy/done handshake.
- Trades latency for area: one bit position per clock, instead of a full barrel shifter.

Parameters:
- N, 8, datapath width in bits (N >= 2).
- SHAMT_W, 3, width of shift-amount input; max shift = 2^SHAMT_W - 1, required <= N-1.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only when busy=0.
- op  input  2  00 SLL, 01 SRL, 10 SRA, 11 ROL; latched on accepted start.
- data_in  input  N  operand; latched on accepted start.
- shamt  input  SHAMT_W  shift amount; latched on accepted start.
- busy  output  1  high while a shift is in progress (state SHIFT).
- done  output  1  one-cycle pulse: result valid.
- result  output  N  shifted value; held stable from done until the next accepted start.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - busy=0, done=0, result=0.
  - count=0, op register=00.
- States: IDLE, SHIFT, DONE. busy=1 only in SHIFT; done=1 only in DONE.
- Start acceptance:
  - A start is accepted on a rising edge where start=1 and state is IDLE or DONE (back-to-back allowed).
  - On acceptance, load work register (drives result) with data_in; load count=shamt; latch op.
  - Next state is DONE if shamt=0, else SHIFT.
- SHIFT, each edge:
  - Work register updated by one position:
    - SLL: {w[N-2:0],0}
    - SRL: {0,w[N-1:1]}
    - SRA: {w[N-1],w[N-1:1]}
    - ROL: {w[N-2:0],w[N-1]}
  - count decrements.
  - When count was 1 before the edge, next state is DONE.
- DONE: lasts exactly one cycle. Next state is SHIFT/DONE if start is accepted on that edge, else IDLE.
- Latency: for an accepted start on edge T with shamt=k, done is high in the cycle after edge T+k. shamt=0 gives done after edge T.
- result:
  - Changes during SHIFT (intermediate values visible).
  - Guaranteed correct while done=1.
  - Holds in IDLE.
- start while busy=1: ignored, with no effect on state, count, op or work register.
- Inputs data_in, shamt and op may change freely after acceptance.
- rst_n asserted mid-SHIFT: immediate return to reset values; no done pulse for the aborted operation.
- done and busy are never simultaneously high.

Optional Feature:
- Macro: SHIFT_SEQ_FAST_EN.
- Defined: in SHIFT, when count >= 2, the work register shifts two positions per edge (same op semantics applied twice) and count decrements by 2. When count = 1, it shifts one position. Latency becomes ceil(k/2) edges after T.
- Undefined: one position per edge exactly as above; no two-step path is synthesized.

Test Plan:
- Reset: hold rst_n=0 with start=1 toggling -> busy=0, done=0, result=0x00. After release with start=0, stays IDLE.
- SLL: data_in=0x96, shamt=3, op=00, start on edge T -> busy high after T; done pulses after edge T+3; result=0xB0.
- SRL/SRA: data_in=0x96, shamt=2 -> op=01 gives result 0x25; op=10 gives result 0xE5; done after edge T+2 in both.
- ROL and zero shift: data_in=0x96, shamt=3, op=11 -> 0xB4. Then data_in=0x5A, shamt=0 -> done after edge T, result=0x5A, busy never asserted.
- Busy/back-to-back/reset: start (0x01, shamt=7, SLL); assert start with other data at T+2 -> ignored, result=0x80 at done. Start again in the DONE cycle (0x80, shamt=1, SRL) -> result=0x40. A third op with rst_n pulsed low at T+2 -> all outputs zero, no done.
- SHIFT_SEQ_FAST_EN defined: data_in=0x01, shamt=7, SLL -> done after edge T+4, result=0x80. shamt=2, SRA on 0x80 -> done after T+1, result=0xE0.
